uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868 (100 MHz / 115200 baud); legal range 16..65535; meaning: clock cycles per serial bit.
REQ-002 SHALL have port clock, input, 1, the single system clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port rx, input, 1, asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 SHALL have port byte_out, output, 8, last correctly framed byte received.
REQ-006 SHALL have port byte_ready, output, 1, single-cycle pulse marking byte_out newly valid; drives the command decoder's byte-in-ready input directly.
REQ-007 SHALL have port framing_error, output, 1, single-cycle pulse when the stop bit samples low.
REQ-008 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-009 SHALL pass rx through a two-flop synchronizer (rx_sync); both flops hold 1 during reset; all decisions use rx_sync only.
REQ-010 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-011 SHALL keep a bit-timing counter, width ceil(log2(CLKS_PER_BIT)); counter clears on every state transition; never wraps past CLKS_PER_BIT-1.
REQ-012 IDLE: rx_sync==0 -> START, counter=0; otherwise remain.
REQ-013 START: at counter==CLKS_PER_BIT/2-1, rx_sync==0 -> DATA with bit index 0; rx_sync==1 -> IDLE (glitch rejected, no output pulse).
REQ-014 DATA: at counter==CLKS_PER_BIT-1, shift rx_sync into bit position [bit index] of shift register; after bit index 7 -> STOP, else increment bit index (3-bit).
REQ-015 STOP: at counter==CLKS_PER_BIT-1, rx_sync==1 -> load byte_out from shift register, pulse byte_ready, -> IDLE; rx_sync==0 -> pulse framing_error, byte_out unchanged, -> WAIT_HIGH.
REQ-016 WAIT_HIGH: remain until rx_sync==1, then -> IDLE; a line held low (break) SHALL produce exactly one framing_error and no byte_ready.
REQ-017 byte_ready and framing_error SHALL be registered, high for exactly one clock, in the cycle after the stop-bit sample edge; never both high.
REQ-018 byte_out SHALL hold its value between pulses; downstream may sample it any time byte_ready is high or later until the next byte_ready.
REQ-019 Back-to-back frames (start bit immediately after stop bit) SHALL be received without loss; IDLE detects the new start on the first low rx_sync cycle.
REQ-020 Latency, rx start-bit falling edge to byte_ready: 2 (sync) + 1 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles, +/-1.

Reset
REQ-021 While reset high: state=IDLE, counter=0, bit index=0, shift register=0x00, byte_out=0x00, byte_ready=0, framing_error=0, busy=0, synchronizer flops=1.
REQ-022 Reset asserted mid-frame SHALL abandon the frame with no pulse; after release the remainder of the aborted frame may be misread, but the first frame starting after line idle-high for at least one bit time SHALL be received correctly.

Structure
REQ-023 Shared package la_pkg SHALL hold the uart_rx state typedef (uart_rx_state_t) and the constant DEFAULT_CLKS_PER_BIT=868.
REQ-024 Synchronizer SHALL be a separate sub-module sync_2ff (1-bit, parameterised reset value), reusable for other asynchronous analyzer inputs.
REQ-025 No other sub-modules; combined RTL target 120-250 lines.

Verification (CLKS_PER_BIT=16 unless stated)
REQ-026 Send 0xA5, ideal timing -> exactly one byte_ready, byte_out==0xA5, framing_error never high, busy low afterwards.
REQ-027 Send 0x00 then 0xFF back-to-back, no idle gap -> two byte_ready pulses, values 0x00 then 0xFF in order.
REQ-028 rx low for 4 cycles then high -> no byte_ready, no framing_error, returns to IDLE within 12 cycles.
REQ-029 Send 0x5A with stop bit low, then hold rx low 40 bit-times, release, send 0x3C -> one framing_error, byte_out stays 0x00 until the 0x3C frame completes, then one byte_ready with 0x3C.
REQ-030 Assert reset 1 cycle during bit 3 of a frame, idle 2 bit-times, send 0x81 -> all outputs at reset values during reset; next byte_ready carries 0x81.
REQ-031 Integration, CLKS_PER_BIT=868, bit period +/-2% -> 5 frames 0x02,0x12,0x34,0x56,0x78 fed to the command decoder -> opcode 0x02, command 0x12345678.

Source files
------------

// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyzer front end.
//
// Contents:
//   DEFAULT_CLKS_PER_BIT - bit period in clocks for a 100 MHz clock at 115200 baud
//   uart_rx_state_t      - state encoding for the uart_rx receiver FSM
//   ST_*                 - uart_rx state constants
package la_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 868;

  // Plain vector encoding so the states can be used by older tools and
  // compared directly against captured analyzer traces.
  typedef logic [2:0] uart_rx_state_t;

  localparam uart_rx_state_t ST_IDLE      = 3'd0;
  localparam uart_rx_state_t ST_START     = 3'd1;
  localparam uart_rx_state_t ST_DATA      = 3'd2;
  localparam uart_rx_state_t ST_STOP      = 3'd3;
  localparam uart_rx_state_t ST_WAIT_HIGH = 3'd4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous input bit.
//
// Parameters:
//   RESET_VAL - value both flops take while reset is high
// Ports:
//   clock - system clock, rising edge
//   reset - synchronous active-high reset
//   d     - asynchronous input
//   q     - synchronized output, two clocks behind d
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // First flop may go metastable; the second gives it a full cycle to settle.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, idle-high line.
//
// Parameters:
//   CLKS_PER_BIT  - clock cycles per serial bit (16..65535)
// Ports:
//   clock         - system clock, rising edge
//   reset         - synchronous active-high reset
//   rx            - asynchronous serial input
//   byte_out      - last correctly framed byte, held between pulses
//   byte_ready    - one-cycle pulse when byte_out is newly valid
//   framing_error - one-cycle pulse when the stop bit samples low
//   busy          - high whenever the receiver is not idle
module uart_rx
  import la_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_out,
  output logic       byte_ready,
  output logic       framing_error,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic rx_sync;

  uart_rx_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       byte_out_q, byte_out_d;
  logic             byte_ready_q, byte_ready_d;
  logic             framing_error_q, framing_error_d;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start.
  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync_rx (
    .clock(clock),
    .reset(reset),
    .d    (rx),
    .q    (rx_sync)
  );

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    bit_idx_d       = bit_idx_q;
    shift_d         = shift_q;
    byte_out_d      = byte_out_q;
    byte_ready_d    = 1'b0;
    framing_error_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_sync) begin
          state_d = ST_START;
        end
      end

      // Re-check the start bit at its midpoint; this both rejects short
      // glitches and aligns every later sample to mid-bit.
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rx_sync) begin
            state_d   = ST_DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_sync;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Returning to IDLE at mid-stop leaves half a bit of slack to catch
      // a start bit that follows immediately.
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_sync) begin
            byte_out_d   = shift_q;
            byte_ready_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            framing_error_d = 1'b1;
            state_d         = ST_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // A held-low line (break) must not be mistaken for a stream of
      // zero bytes, so wait for the line to recover before re-arming.
      ST_WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_sync) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      bit_idx_q       <= 3'd0;
      shift_q         <= 8'h00;
      byte_out_q      <= 8'h00;
      byte_ready_q    <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      bit_idx_q       <= bit_idx_d;
      shift_q         <= shift_d;
      byte_out_q      <= byte_out_d;
      byte_ready_q    <= byte_ready_d;
      framing_error_q <= framing_error_d;
    end
  end

  assign byte_out      = byte_out_q;
  assign byte_ready    = byte_ready_q;
  assign framing_error = framing_error_q;
  assign busy          = (state_q != ST_IDLE);

endmodule
